// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, divisor width and baud helpers.
// Used by the APB slave interface, the baud generator and the shift stage.
package spi_pkg;

  localparam int DIV_W = 12;

  localparam logic [1:0] SPI_RUN  = 2'b00;
  localparam logic [1:0] SPI_WAIT = 2'b01;
  localparam logic [1:0] SPI_STOP = 2'b10;

  // Half sclk period in PClk cycles: (sppr+1) << spr, range 1..1024.
  function automatic logic [DIV_W-1:0] spi_half(input logic [2:0] sppr,
                                                input logic [2:0] spr);
    logic [DIV_W-1:0] base;
    base = DIV_W'(sppr) + DIV_W'(1);
    return base << spr;
  endfunction

  // Full baud divisor: (sppr+1) << (spr+1), range 2..2048.
  function automatic logic [DIV_W-1:0] spi_divisor(input logic [2:0] sppr,
                                                   input logic [2:0] spr);
    return spi_half(sppr, spr) << 1;
  endfunction

endpackage

// File: rtl/spi_baud_generator.sv
// SPI baud generator: divides PClk into the registered serial clock and
// raises one-cycle send/receive strobes in the cycle before each sclk edge.
// Timing config (HALF, cpha) is frozen for the duration of a transfer.
module spi_baud_generator
  import spi_pkg::*;
(
  input  logic             PClk,
  input  logic             PRESET,
  input  logic [1:0]       spi_mode,
  input  logic             spiswai,
  input  logic [2:0]       sppr,
  input  logic [2:0]       spr,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             ss,
  output logic             sclk,
  output logic             send_flag,
  output logic             receive_flag,
  output logic [DIV_W-1:0] BaudRateDivisor
);

  logic             active;
  logic             act_q;
  logic [DIV_W-1:0] half_live, half_q, half_eff;
  logic             cpha_q, cpha_eff;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             p_q, p_d;
  logic             sclk_q, sclk_d;
  logic             term;
  logic             cfg_load;

  // Transfer qualifier, live divisor and effective (frozen or live) config.
  // The first active cycle (act_q still 0) uses the live values, which are
  // captured in that same cycle and held until the transfer ends.
  always_comb begin
    active          = !ss && ((spi_mode == SPI_RUN) ||
                              ((spi_mode == SPI_WAIT) && !spiswai));
    half_live       = spi_half(sppr, spr);
    BaudRateDivisor = spi_divisor(sppr, spr);
    cfg_load        = !active || !act_q;
    half_eff        = act_q ? half_q : half_live;
    cpha_eff        = act_q ? cpha_q : cpha;
    term            = (cnt_q == (half_eff - DIV_W'(1)));
  end

  // Strobes precede the sclk edge by one PClk; forced low while in reset.
  always_comb begin
    receive_flag = !PRESET && active && term && (p_q == cpha_eff);
    send_flag    = !PRESET && active && term && (p_q != cpha_eff);
  end

  // Counter / phase / sclk next state.
  always_comb begin
    cnt_d  = cnt_q;
    p_d    = p_q;
    sclk_d = sclk_q;
    if (!active) begin
      cnt_d  = '0;
      p_d    = 1'b0;
      sclk_d = cpol;
    end else if (term) begin
      cnt_d  = '0;
      p_d    = ~p_q;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + DIV_W'(1);
    end
  end

  // Divider state registers.
  always_ff @(posedge PClk or posedge PRESET) begin
    if (PRESET) begin
      cnt_q  <= '0;
      p_q    <= 1'b0;
      sclk_q <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      sclk_q <= sclk_d;
      act_q  <= active;
    end
  end

  // Config latch: tracks live inputs until the first active cycle, then holds.
  always_ff @(posedge PClk or posedge PRESET) begin
    if (PRESET) begin
      cpha_q <= 1'b0;
      half_q <= DIV_W'(1);
    end else if (cfg_load) begin
      cpha_q <= cpha;
      half_q <= half_live;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: doc/spi_baud_generator.md
Name: spi_baud_generator

Overview:
- Generates the SPI serial clock (sclk) and one-cycle send/receive strobes for the SPI shift stage.
- Sits directly downstream of the APB slave interface. Consumes its sppr, spr, cpol, cpha, spiswai and spi_mode outputs plus the active-low slave select.
- Pure PClk-domain design: sclk is a registered divided clock, never used as a clock inside this block.

Parameters:
- DIV_W, 12, width of the baud divisor. The maximum divisor is 8*256 = 2048, so 12 bits are required.

Ports:
- PClk  input  1  system clock; all state updates on its rising edge
- PRESET  input  1  reset, asynchronous and active-high (one clock, async active-high reset)
- spi_mode  input  2  00 run, 01 wait, 10 stop; 11 is treated as stop
- spiswai  input  1  1 = halt sclk while in wait mode
- sppr  input  3  baud pre-selection
- spr  input  3  baud selection
- cpol  input  1  sclk idle level
- cpha  input  1  0 = sample on leading edge; 1 = sample on trailing edge
- ss  input  1  active-low slave select; a transfer is in progress while 0
- sclk  output  1  serial clock, registered
- send_flag  output  1  one-PClk pulse: the next sclk edge is a shift-out edge
- receive_flag  output  1  one-PClk pulse: the next sclk edge is a sample edge
- BaudRateDivisor  output  DIV_W  (sppr+1)*2^(spr+1), combinational from the live inputs

Behaviour:
- Divisor: BaudRateDivisor = (sppr+1) << (spr+1), range 2..2048. The half period is HALF = (sppr+1) << spr, range 1..1024.
- Run condition: active = !ss & (spi_mode==00 | (spi_mode==01 & !spiswai)).
- Configuration latching:
  - While not active, the latched cpol, cpha and HALF copy the live inputs every cycle.
  - On the first active cycle they freeze, and stay frozen until active drops.
  - Mid-transfer changes to sppr, spr, cpol or cpha have no effect on sclk.
- Registered state: cnt[DIV_W-1:0], phase p (0 means the next edge is the leading edge), sclk.
- Reset (async, PRESET=1): cnt=0, p=0, sclk=0, latched cpol/cpha=0, latched HALF=1. The flags read 0 because active terminates nothing during reset.
- Idle (active=0): cnt<=0, p<=0, sclk<=live cpol. Both flags are 0.
- Active counting:
  - Terminal cycle: term = (cnt == HALF-1).
  - If term: cnt<=0, p<=~p, sclk<=~sclk. Otherwise cnt<=cnt+1.
  - The first sclk edge occurs HALF PClk cycles after active rises.
- Flags (combinational from registered state, valid in the term cycle, so the sclk edge follows on the next PClk edge):
  - receive_flag = active & term & (p == latched cpha)
  - send_flag = active & term & (p != latched cpha)
  - The two flags are never high together.
- HALF=1 (sppr=0, spr=0): term is true every active cycle. sclk toggles every PClk, and the flags alternate every cycle.
- Deactivation mid-period (ss rises, stop mode entered, or wait with spiswai=1): the next cycle returns to idle. Counter and phase clear, sclk returns to cpol, and no partial-period flag is emitted.
- Reactivation: always restarts from cnt=0, p=0. Wait-mode halt does not resume mid-period.
- Reset asserted mid-transfer: all state clears immediately (asynchronously). After release, sclk resumes at cpol on the first idle cycle.
- No arithmetic overflow: the counter never exceeds HALF-1 (max 1023).

Decomposition:
- Shared package spi_pkg holds:
  - mode constants SPI_RUN=2'b00, SPI_WAIT=2'b01, SPI_STOP=2'b10
  - DIV_W
  - a function computing the divisor/HALF from sppr and spr
- The same package is also used by the APB slave interface and the shift stage.
- No sub-module: the divisor is a single shift/multiply, and the counter, phase and flag logic form one flat block.

Test Plan:
- sppr=1, spr=1, cpol=0, cpha=0, run, ss 1->0:
  - BaudRateDivisor=8, HALF=4; first sclk rise 4 PClk after ss falls, then sclk period 8 PClk.
  - receive_flag in the cycle before each rising edge; send_flag before each falling edge.
- sppr=0, spr=0, cpol=1, cpha=1:
  - sclk idles 1, toggles every PClk while active.
  - send_flag and receive_flag alternate each cycle, send_flag first.
- sppr=7, spr=7: BaudRateDivisor=2048; sclk high/low phases each 1024 PClk; no flags between edges.
- Active transfer, then spi_mode=01 with spiswai=1:
  - Next cycle sclk=cpol, flags 0, cnt=0.
  - Set spiswai=0: the first edge arrives after a full HALF again.
  - Repeat with spi_mode=10: same halt.
- Change sppr from 1 to 3 mid-transfer: the period stays 8 PClk until ss rises; the next transfer runs at period 16.
- Assert PRESET mid-period: sclk, flags and cnt go to 0 asynchronously without waiting for PClk. After release, with ss=0 and run, restart matches the first scenario.
